icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped instruction cache between the pipelined datapath's fetch port (datapath side of datapath_cache_if) and the memory controller's instruction port.
- Serves imemREN/imemaddr requests with ihit/imemload.
- On a miss, fetches one word from memory, fills the frame, and returns the word.
- Keeps saturating hit and miss counters for performance reporting.

Parameters:
- NSETS, 16, number of frames; power of two, at least 2.
- IDX_W, $clog2(NSETS), index width.
- TAG_W, 30-IDX_W, tag width (word-aligned addresses, 2-bit byte offset).

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, word-aligned.
- iwait  in  1  memory busy; iload is valid in the cycle iwait is low while iREN is high.
- iload  in  32  memory read data.
- hit_count  out  32  hits since reset, saturating.
- miss_count  out  32  misses since reset, saturating.

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2], byte offset = [1:0].
- Frame contents: valid bit, tag, 32-bit data.
- Reset (RST high, asynchronous):
  - state IDLE; all valid bits 0.
  - ihit 0, iREN 0, iaddr 0, imemload 0.
  - both counters 0.
  - Reset asserted during FETCH aborts the fill: no frame is written and iREN drops immediately.
- FSM has two states, IDLE and FETCH.
- IDLE:
  - Hit = imemREN & valid[idx] & tag match. ihit=1 combinationally in the same cycle; imemload = frame data; zero-latency hit.
  - On a hit, hit_count increments at the clock edge.
  - imemREN=1 and no hit: ihit=0. Latch miss_addr = {imemaddr[31:2],2'b00}. Increment miss_count. Next state FETCH.
  - imemREN=0: ihit=0, imemload=0, no state change, no counting.
- FETCH:
  - iREN=1, iaddr=miss_addr.
  - While iwait=1: ihit=0; hold state.
  - When iwait=0 (fill cycle):
    - write frame[miss_addr idx] = {1, miss tag, iload}.
    - ihit = imemREN & (imemaddr[31:2]==miss_addr[31:2]); imemload=iload (forward).
    - next state IDLE.
  - A forwarded fill does not increment hit_count.
- Redirect during FETCH: if imemaddr changes (branch or jump), the fill still completes to miss_addr and ihit stays 0 for the new address. After returning to IDLE, the new address is evaluated normally. A miss is never cancelled.
- imemREN dropping during FETCH does not cancel the fill.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- No write port; instruction memory is read-only through this block.
- Same-cycle hit and fill are impossible: a hit requires IDLE, a fill requires FETCH.
- Only one miss is outstanding at a time; iREN never asserts in IDLE.

Decomposition:
- cpu_types_pkg gains icachef_t, a packed struct {tag, idx, bytoff} overlaid on word_t.
- cpu_types_pkg gains icache_state_t, enum {IDLE, FETCH}.
- Sub-module icache_frame_array holds the NSETS frames.
  - one read port (idx → valid, tag, data).
  - one write port (wen, widx, wtag, wdata).
  - asynchronous clear of valid bits on RST.
- FSM, counters and output muxing live in icache_direct.
- word_t comes from cpu_types_pkg.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait high 3 cycles then low with iload=0x2001_0005.
  - iREN=1 and iaddr=0x40 for 4 cycles.
  - ihit=1 and imemload=0x2001_0005 in the fill cycle.
  - miss_count=1.
- Warm hit: re-request 0x40.
  - ihit=1 in the same cycle, imemload=0x2001_0005, iREN=0.
  - hit_count increments by 1 per cycle held.
- Conflict eviction (NSETS=16): 0x40 then 0x440, same idx 0, different tag.
  - second request misses and refills.
  - a subsequent 0x40 misses again; miss_count=3.
- Redirect mid-fill: miss on 0x80; during iwait=1 change imemaddr to 0x100.
  - fill writes 0x80's frame and ihit=0 in the fill cycle.
  - next cycle, 0x100 starts its own FETCH with iaddr=0x100.
- Reset mid-fill: assert RST while in FETCH.
  - iREN=0 immediately, counters 0.
  - re-request of the same address misses.
- Saturation: force miss_count to 0xFFFF_FFFE via back-door, then take two misses.
  - miss_count=0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type plus instruction-cache address overlay and FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: NSETS direct-mapped frames (valid, tag, data).
// One async-read port and one write port; valid bits clear asynchronously on reset.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS,
    parameter int IDX_W = $clog2(NSETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic             rvalid_o,
    output logic [TAG_W-1:0] rtag_o,
    output word_t            rdata_o,
    input  logic             wen_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  word_t            wdata_i
);

    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [NSETS];
    word_t            data_q [NSETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            valid_q <= '0;
        else if (wen_i)
            valid_q[widx_i] <= 1'b1;
    end

    // Tag/data need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache with zero-latency hits, single-word
// miss fill with forwarding, and saturating hit/miss counters.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS,
    parameter int IDX_W = $clog2(NSETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output word_t hit_count,
    output word_t miss_count
);

    icache_state_t state_q, state_d;
    logic [29:0]   miss_word_q, miss_word_d;
    word_t         hit_cnt_q, hit_cnt_d;
    word_t         miss_cnt_q, miss_cnt_d;

    logic             rvalid;
    logic [TAG_W-1:0] rtag;
    word_t            rdata;
    logic             hit, miss, fill;
    logic             unused_bytoff;

    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(.NSETS(NSETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ridx_i   (imemaddr[IDX_W+1:2]),
        .rvalid_o (rvalid),
        .rtag_o   (rtag),
        .rdata_o  (rdata),
        .wen_i    (fill),
        .widx_i   (miss_word_q[IDX_W-1:0]),
        .wtag_i   (miss_word_q[29:IDX_W]),
        .wdata_i  (iload)
    );

    always_comb begin
        hit         = (state_q == IDLE) && imemREN && rvalid && (rtag == imemaddr[31:IDX_W+2]);
        miss        = (state_q == IDLE) && imemREN && !hit;
        fill        = (state_q == FETCH) && !iwait;
        state_d     = miss ? FETCH : (fill ? IDLE : state_q);
        miss_word_d = miss ? imemaddr[31:2] : miss_word_q;
        hit_cnt_d   = (hit && hit_cnt_q != '1) ? hit_cnt_q + 32'd1 : hit_cnt_q;
        miss_cnt_d  = (miss && miss_cnt_q != '1) ? miss_cnt_q + 32'd1 : miss_cnt_q;
        // A redirected fetch completes the fill but must not claim the new address.
        ihit        = hit || (fill && imemREN && (imemaddr[31:2] == miss_word_q));
        imemload    = hit ? rdata : (fill ? iload : '0);
        iREN        = (state_q == FETCH);
        iaddr       = iREN ? {miss_word_q, 2'b00} : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_word_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_word_q <= miss_word_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: scripted scoreboard bench for icache_direct.
// Each cycle pushes its expected outputs when inputs are driven and pops them when sampled.
module tb_icache_direct;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  imemREN = 1'b0;
    word_t imemaddr = '0;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait = 1'b1;
    word_t iload = '0;
    word_t hit_count;
    word_t miss_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        string t;
        logic  e_hit;
        word_t e_load;
        logic  e_ren;
        word_t e_addr;
    } exp_t;

    exp_t sb[$];

    icache_direct dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string t, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", t, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge, sample combinational outputs 2ns later.
    task automatic cyc(input string t, input logic ren, input word_t a, input logic w, input word_t ld,
                       input logic e_hit, input word_t e_load, input logic e_ren, input word_t e_addr);
        exp_t e;
        @(negedge CLK);
        imemREN = ren;
        imemaddr = a;
        iwait = w;
        iload = ld;
        sb.push_back('{t, e_hit, e_load, e_ren, e_addr});
        #2;
        e = sb.pop_front();
        chk({e.t, ".ihit"}, {31'd0, ihit}, {31'd0, e.e_hit});
        chk({e.t, ".iREN"}, {31'd0, iREN}, {31'd0, e.e_ren});
        if (e.e_hit) chk({e.t, ".imemload"}, imemload, e.e_load);
        if (e.e_ren) chk({e.t, ".iaddr"}, iaddr, e.e_addr);
    endtask

    initial begin
        #2;
        chk("rst.ihit", {31'd0, ihit}, 32'd0);
        chk("rst.iREN", {31'd0, iREN}, 32'd0);
        chk("rst.iaddr", iaddr, 32'd0);
        chk("rst.imemload", imemload, 32'd0);
        chk("rst.hit_count", hit_count, 32'd0);
        chk("rst.miss_count", miss_count, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        cyc("cold_idle", 1, 32'h40, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("cold_wait", 1, 32'h40, 1, 0, 0, 0, 1, 32'h40);
        cyc("cold_fill", 1, 32'h40, 0, 32'h2001_0005, 1, 32'h2001_0005, 1, 32'h40);
        chk("cold.miss_count", miss_count, 32'd1);
        chk("cold.hit_count", hit_count, 32'd0);

        for (int i = 0; i < 3; i++)
            cyc("warm_hit", 1, 32'h40, 1, 32'hDEAD_BEEF, 1, 32'h2001_0005, 0, 0);

        cyc("evict_idle", 1, 32'h440, 1, 0, 0, 0, 0, 0);
        chk("warm.hit_count", hit_count, 32'd3);
        cyc("evict_fill", 1, 32'h440, 0, 32'hAAAA_0440, 1, 32'hAAAA_0440, 1, 32'h440);
        cyc("evict_again", 1, 32'h40, 1, 0, 0, 0, 0, 0);
        cyc("evict_refill", 1, 32'h40, 0, 32'h2001_0005, 1, 32'h2001_0005, 1, 32'h40);
        chk("evict.miss_count", miss_count, 32'd3);
        chk("evict.hit_count", hit_count, 32'd3);

        cyc("redir_idle", 1, 32'h80, 1, 0, 0, 0, 0, 0);
        cyc("redir_wait", 1, 32'h80, 1, 0, 0, 0, 1, 32'h80);
        cyc("redir_jump", 1, 32'h100, 1, 0, 0, 0, 1, 32'h80);
        cyc("redir_fill", 1, 32'h100, 0, 32'hBBBB_0080, 0, 0, 1, 32'h80);
        cyc("redir_new", 1, 32'h100, 1, 0, 0, 0, 0, 0);
        cyc("redir_fetch", 1, 32'h100, 0, 32'hCCCC_0100, 1, 32'hCCCC_0100, 1, 32'h100);
        chk("redir.miss_count", miss_count, 32'd5);

        cyc("drop_idle", 1, 32'h204, 1, 0, 0, 0, 0, 0);
        cyc("drop_fill", 0, 32'h204, 0, 32'hDDDD_0204, 0, 0, 1, 32'h204);
        cyc("drop_hit", 1, 32'h204, 1, 0, 1, 32'hDDDD_0204, 0, 0);
        cyc("drop_hit2", 1, 32'h100, 1, 0, 1, 32'hCCCC_0100, 0, 0);
        chk("drop.hit_count", hit_count, 32'd4);

        cyc("rst_idle", 1, 32'h1C0, 1, 0, 0, 0, 0, 0);
        cyc("rst_wait", 1, 32'h1C0, 1, 0, 0, 0, 1, 32'h1C0);
        @(negedge CLK);
        RST = 1'b1;
        imemREN = 1'b0;
        iwait = 1'b0;
        iload = 32'hEEEE_01C0;
        #2;
        chk("rst_mid.iREN", {31'd0, iREN}, 32'd0);
        chk("rst_mid.hit_count", hit_count, 32'd0);
        chk("rst_mid.miss_count", miss_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cyc("rst_rereq", 1, 32'h1C0, 1, 0, 0, 0, 0, 0);
        cyc("rst_refill", 1, 32'h1C0, 0, 32'h1111_01C0, 1, 32'h1111_01C0, 1, 32'h1C0);
        cyc("rst_old_miss", 1, 32'h204, 1, 0, 0, 0, 0, 0);
        cyc("rst_old_fill", 1, 32'h204, 0, 32'h2222_0204, 1, 32'h2222_0204, 1, 32'h204);
        chk("rst_after.miss_count", miss_count, 32'd2);

        @(negedge CLK);
        imemREN = 1'b0;
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        @(negedge CLK);
        release dut.miss_cnt_q;
        cyc("sat_idle1", 1, 32'h300, 1, 0, 0, 0, 0, 0);
        cyc("sat_fill1", 1, 32'h300, 0, 32'h3333_0300, 1, 32'h3333_0300, 1, 32'h300);
        chk("sat.miss_count1", miss_count, 32'hFFFF_FFFF);
        cyc("sat_idle2", 1, 32'h340, 1, 0, 0, 0, 0, 0);
        cyc("sat_fill2", 1, 32'h340, 0, 32'h3333_0340, 1, 32'h3333_0340, 1, 32'h340);
        chk("sat.miss_count2", miss_count, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
